// File: rtl/drf_pkg.sv
// Shared DRF definitions: arbiter state encoding, bus-driver indices and the
// default driver count.
package drf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  localparam int unsigned REQ_CU    = 0;
  localparam int unsigned REQ_ALU   = 1;
  localparam int unsigned REQ_REG   = 2;
  localparam int unsigned REQ_MEM   = 3;
  localparam int unsigned DRF_N_REQ = 4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: the first set request at or after i_ptr, wrapping
// modulo N_REQ. Purely combinational.
module rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]         o_onehot,
  output logic [$clog2(N_REQ)-1:0] o_idx,
  output logic                     o_valid
);

  localparam int unsigned IDW = $clog2(N_REQ);

  always_comb begin
    int unsigned v_idx;
    logic [IDW-1:0] v_sel;
    v_idx    = 0;
    v_sel    = '0;
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      v_idx = (32'(i_ptr) + i) % N_REQ;
      v_sel = IDW'(v_idx);
      if (!o_valid && i_req[v_sel]) begin
        o_valid         = 1'b1;
        o_idx           = v_sel;
        o_onehot[v_sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/drf_bus_arbiter.sv
// Round-robin arbiter for the shared DRF bus with locked transfers, a hold
// timeout and one forced dead turnaround cycle between grants.
module drf_bus_arbiter
  import drf_pkg::*;
#(
  parameter int unsigned N_REQ   = DRF_N_REQ,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         in_req,
  input  logic [N_REQ-1:0]         in_lock,
  output logic [N_REQ-1:0]         out_grant,
  output logic [$clog2(N_REQ)-1:0] out_grant_id,
  output logic                     out_bus_idle,
  output logic                     out_timeout
);

  localparam int unsigned IDW     = $clog2(N_REQ);
  localparam logic [7:0]  TMO_MAX = 8'(TIMEOUT);

  arb_state_t       r_state, w_state;
  logic [N_REQ-1:0] r_grant, w_grant;
  logic [IDW-1:0]   r_grant_id, w_grant_id;
  logic [IDW-1:0]   r_rr_ptr, w_rr_ptr;
  logic [7:0]       r_cnt, w_cnt;
  logic             r_timeout, w_timeout;
  logic             r_idle, w_idle;

  logic [N_REQ-1:0] w_pick_onehot;
  logic [IDW-1:0]   w_pick_idx;
  logic             w_pick_valid;
  logic             w_owner_hold;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .i_req    (in_req),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  // Lock counts only for the owner and only while it keeps requesting.
  assign w_owner_hold = in_req[r_grant_id] && in_lock[r_grant_id];

  always_comb begin
    w_state    = r_state;
    w_grant    = r_grant;
    w_grant_id = r_grant_id;
    w_rr_ptr   = r_rr_ptr;
    w_cnt      = r_cnt;
    w_timeout  = 1'b0;
    w_idle     = r_idle;
    unique case (r_state)
      GRANT: begin
        if (w_owner_hold && (r_cnt < TMO_MAX)) begin
          w_cnt = r_cnt + 8'd1;
        end else begin
          w_state   = TURN;
          w_grant   = '0;
          w_idle    = 1'b1;
          w_rr_ptr  = (r_grant_id == IDW'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;
          w_timeout = w_owner_hold;
        end
      end
      default: begin
        if (w_pick_valid) begin
          w_state    = GRANT;
          w_grant    = w_pick_onehot;
          w_grant_id = w_pick_idx;
          w_cnt      = 8'd1;
          w_idle     = 1'b0;
        end else begin
          w_state = IDLE;
          w_grant = '0;
          w_idle  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
      r_idle     <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_grant    <= w_grant;
      r_grant_id <= w_grant_id;
      r_rr_ptr   <= w_rr_ptr;
      r_cnt      <= w_cnt;
      r_timeout  <= w_timeout;
      r_idle     <= w_idle;
    end
  end

  assign out_grant    = r_grant;
  assign out_grant_id = r_grant_id;
  assign out_bus_idle = r_idle;
  assign out_timeout  = r_timeout;

endmodule

// File: tb/tb_drf_bus_arbiter.sv
// Directed bench for drf_bus_arbiter: reset, single requester, full
// contention, timeout, early release and asynchronous reset mid-lock.
module tb_drf_bus_arbiter;

  localparam int unsigned N_REQ   = 4;
  localparam int unsigned TIMEOUT = 15;

  logic             clk;
  logic             rst_n;
  logic [N_REQ-1:0] in_req;
  logic [N_REQ-1:0] in_lock;
  logic [N_REQ-1:0] out_grant;
  logic [1:0]       out_grant_id;
  logic             out_bus_idle;
  logic             out_timeout;

  int n_eval = 0;
  int n_fail = 0;

  drf_bus_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_req       (in_req),
    .in_lock      (in_lock),
    .out_grant    (out_grant),
    .out_grant_id (out_grant_id),
    .out_bus_idle (out_bus_idle),
    .out_timeout  (out_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] id,
                           input logic tmo);
    check({tag, ".grant"}, 8'(out_grant), 8'(g));
    check({tag, ".id"},    8'(out_grant_id), 8'(id));
    check({tag, ".idle"},  8'(out_bus_idle), 8'(g == 4'b0000));
    check({tag, ".tmo"},   8'(out_timeout), 8'(tmo));
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    in_req  = '0;
    in_lock = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] seq [9];

    // Reset with random requests held.
    rst_n   = 1'b0;
    in_lock = '0;
    in_req  = 4'($urandom);
    #2;
    for (int i = 0; i < 3; i++) begin
      step();
      in_req = 4'($urandom);
      check_all("reset", 4'b0000, 2'd0, 1'b0);
    end
    in_req = '0;
    rst_n  = 1'b1;
    step();
    check_all("idle", 4'b0000, 2'd0, 1'b0);

    // Single unlocked requester alternates grant / turnaround.
    in_req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step();
      check_all("single", (i % 2 == 0) ? 4'b0010 : 4'b0000, 2'd1, 1'b0);
    end

    // Full contention, round-robin from index 0.
    do_reset();
    in_req = 4'b1111;
    seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    for (int i = 0; i < 9; i++) begin
      step();
      check("rr.grant", 8'(out_grant), 8'(seq[i]));
    end
    check("rr.id", 8'(out_grant_id), 8'd0);

    // Timeout on a locked owner with a second driver waiting.
    do_reset();
    in_req  = 4'b0100;
    in_lock = 4'b0100;
    step();
    in_req = 4'b1100;
    check_all("tmo.c1", 4'b0100, 2'd2, 1'b0);
    for (int i = 2; i <= 15; i++) begin
      step();
      check("tmo.hold", 8'(out_grant), 8'b0100);
      check("tmo.nopulse", 8'(out_timeout), 8'd0);
    end
    step();
    check_all("tmo.turn", 4'b0000, 2'd2, 1'b1);
    step();
    check_all("tmo.next", 4'b1000, 2'd3, 1'b0);
    step();
    check_all("tmo.unlk", 4'b0000, 2'd3, 1'b0);
    in_req  = '0;
    in_lock = '0;

    // Early release: owner 1 locked for 3 cycles, then drops its request.
    do_reset();
    in_req  = 4'b0010;
    in_lock = 4'b0010;
    step();
    in_req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      check_all("early.hold", 4'b0010, 2'd1, 1'b0);
    end
    in_req = 4'b0001;
    step();
    check_all("early.turn", 4'b0000, 2'd1, 1'b0);
    step();
    check_all("early.next", 4'b0001, 2'd0, 1'b0);
    in_req  = '0;
    in_lock = '0;

    // Asynchronous reset during a locked grant to index 3.
    do_reset();
    in_req  = 4'b1000;
    in_lock = 4'b1000;
    step();
    step();
    step();
    check_all("rml.hold", 4'b1000, 2'd3, 1'b0);
    in_req = 4'b1001;
    rst_n  = 1'b0;
    #1;
    check_all("rml.async", 4'b0000, 2'd0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    check_all("rml.first", 4'b0001, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
